// File: rtl/pipe_pkg.sv
// Shared widths and the WB-stage entry type for the EX/WB pipeline register.
// Widths here size the register-file interface of ex_wb_pipeline_reg.
package pipe_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_forward_mux.sv
// Per-operand WB->EX bypass: register-number compare plus 2:1 data select.
// Only present when EX_WB_FORWARDING_EN is defined.
`ifdef EX_WB_FORWARDING_EN
module wb_forward_mux
    import pipe_pkg::*;
(
    input  logic              wb_write,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] src_num,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] data,
    output logic              hit
);

    assign hit  = wb_write && (wb_dest == src_num);
    assign data = hit ? wb_data : rf_data;

endmodule
`endif

// File: rtl/ex_wb_pipeline_reg.sv
// EX/WB pipeline register driving the register-file write port, with a committed-write
// counter. Define EX_WB_FORWARDING_EN to bypass the WB result onto the EX operands.
module ex_wb_pipeline_reg
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter bit R0_READONLY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_AW-1:0] ex_src1_num,
    input  logic [REG_AW-1:0] ex_src2_num,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [REG_AW-1:0] Write_Reg_Num,
    output logic [DATA_W-1:0] Write_Data,
    output logic              RegWrite,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [1:0]        fwd_hit,
    output logic [CNT_W-1:0]  commit_count
);

    wb_entry_t        wb;
    logic             r0_block;
    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the async clear keeps RegWrite low from the moment reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb <= '0;
        end else begin
            // flush overrides stall so a squashed instruction can never commit
            if (flush) begin
                wb.valid <= 1'b0;
            end else if (!stall) begin
                wb.valid <= ex_valid;
            end
            if (!stall) begin
                wb.we   <= ex_reg_write;
                wb.dest <= ex_dest;
                wb.data <= ex_result;
            end
        end
    end

    assign r0_block      = R0_READONLY && (wb.dest == REG_ZERO);
    assign RegWrite      = wb.valid && wb.we && !r0_block;
    assign Write_Reg_Num = wb.dest;
    assign Write_Data    = wb.data;

    // A stalled write re-presents the same value each cycle; count it on release only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (RegWrite && !stall) begin
            count <= count + CNT_W'(1);
        end
    end

    assign commit_count = count;

`ifdef EX_WB_FORWARDING_EN
    wb_forward_mux u_fwd1 (
        .wb_write (RegWrite),
        .wb_dest  (wb.dest),
        .wb_data  (wb.data),
        .src_num  (ex_src1_num),
        .rf_data  (rf_data1),
        .data     (fwd_data1),
        .hit      (fwd_hit[0])
    );

    wb_forward_mux u_fwd2 (
        .wb_write (RegWrite),
        .wb_dest  (wb.dest),
        .wb_data  (wb.data),
        .src_num  (ex_src2_num),
        .rf_data  (rf_data2),
        .data     (fwd_data2),
        .hit      (fwd_hit[1])
    );
`else
    logic unused_src;

    assign unused_src = ^{ex_src1_num, ex_src2_num};
    assign fwd_data1  = rf_data1;
    assign fwd_data2  = rf_data2;
    assign fwd_hit    = 2'b00;
`endif

endmodule

// File: tb/tb_ex_wb_pipeline_reg.sv
// Self-checking bench for ex_wb_pipeline_reg: directed vector table plus hand sequences
// for reset, mid-operation reset, counter wrap and read-only register 0.
module tb_ex_wb_pipeline_reg;
    import pipe_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall, flush, ex_valid, ex_reg_write;
    logic [REG_AW-1:0] ex_dest, ex_src1_num, ex_src2_num;
    logic [DATA_W-1:0] ex_result, rf_data1, rf_data2;

    logic [REG_AW-1:0] wnum, wnum2;
    logic [DATA_W-1:0] wdata, wdata2, fwd1, fwd2, fwd1b, fwd2b;
    logic              rw, rw2;
    logic [1:0]        hit, hit2;
    logic [15:0]       cnt;
    logic [3:0]        cnt2;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_wb_pipeline_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
        .ex_result(ex_result), .ex_src1_num(ex_src1_num), .ex_src2_num(ex_src2_num),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .Write_Reg_Num(wnum), .Write_Data(wdata), .RegWrite(rw),
        .fwd_data1(fwd1), .fwd_data2(fwd2), .fwd_hit(hit), .commit_count(cnt)
    );

    // Narrow counter and read-only r0 so wrap and r0 suppression are reachable quickly.
    ex_wb_pipeline_reg #(.CNT_W(4), .R0_READONLY(1'b1)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
        .ex_result(ex_result), .ex_src1_num(ex_src1_num), .ex_src2_num(ex_src2_num),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .Write_Reg_Num(wnum2), .Write_Data(wdata2), .RegWrite(rw2),
        .fwd_data1(fwd1b), .fwd_data2(fwd2b), .fwd_hit(hit2), .commit_count(cnt2)
    );

    typedef struct {
        logic       stall, flush, valid, we;
        logic [2:0] dest;
        logic [7:0] result;
        logic [2:0] src1, src2;
        logic [7:0] rf1, rf2;
        logic       chk_data;
        logic [2:0] e_wnum;
        logic [7:0] e_wdata;
        logic       e_rw;
        logic [15:0] e_cnt;
        logic [7:0] e_fwd1, e_fwd2;
        logic [1:0] e_hit;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic v, input logic w,
                         input logic [2:0] d, input logic [7:0] r);
        stall = s; flush = f; ex_valid = v; ex_reg_write = w; ex_dest = d; ex_result = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall flush valid we dest result src1 src2 rf1 rf2 chk | wnum wdata rw cnt fwd1 fwd2 hit
        vecs[0]  = '{0,0,1,1,3,8'hA5, 3,4,8'h01,8'h02, 1, 3,8'hA5,1,0, 8'hA5,8'h02,2'b01};
        vecs[1]  = '{0,0,1,1,5,8'h3C, 1,2,8'h10,8'h20, 1, 5,8'h3C,1,1, 8'h10,8'h20,2'b00};
        vecs[2]  = '{1,0,1,1,7,8'hFF, 5,6,8'h00,8'h22, 1, 5,8'h3C,1,1, 8'h3C,8'h22,2'b01};
        vecs[3]  = '{1,0,1,1,7,8'hFF, 0,5,8'h33,8'h44, 1, 5,8'h3C,1,1, 8'h33,8'h3C,2'b10};
        vecs[4]  = '{1,0,1,1,7,8'hFF, 5,5,8'h00,8'h00, 1, 5,8'h3C,1,1, 8'h3C,8'h3C,2'b11};
        vecs[5]  = '{0,0,1,0,2,8'h77, 2,0,8'h09,8'h0A, 1, 2,8'h77,0,2, 8'h09,8'h0A,2'b00};
        vecs[6]  = '{0,0,0,1,4,8'h12, 4,4,8'h55,8'h66, 1, 4,8'h12,0,2, 8'h55,8'h66,2'b00};
        vecs[7]  = '{0,0,1,1,2,8'h11, 2,2,8'h00,8'h00, 1, 2,8'h11,1,2, 8'h11,8'h11,2'b11};
        vecs[8]  = '{1,1,1,1,6,8'h99, 2,3,8'h01,8'h02, 0, 0,8'h00,0,2, 8'h01,8'h02,2'b00};
        vecs[9]  = '{0,1,1,1,1,8'hAB, 1,1,8'hC1,8'hC2, 0, 0,8'h00,0,2, 8'hC1,8'hC2,2'b00};
        vecs[10] = '{0,0,1,1,0,8'h5A, 0,7,8'h00,8'hE7, 1, 0,8'h5A,1,2, 8'h5A,8'hE7,2'b01};
        vecs[11] = '{0,0,0,0,0,8'h00, 0,0,8'h03,8'h04, 1, 0,8'h00,0,3, 8'h03,8'h04,2'b00};

        // Reset held while EX presents a writing instruction
        reset = 1'b0;
        drive(0, 0, 1, 1, 3'd3, 8'hA5);
        ex_src1_num = 3'd3; ex_src2_num = 3'd3; rf_data1 = 8'h5E; rf_data2 = 8'h6F;
        tick(); tick();
        check("rst_regwrite", 32'(rw), 32'd0);
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_wnum", 32'(wnum), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_fwd_hit", 32'(hit), 32'd0);
        check("rst_fwd1", 32'(fwd1), 32'h5E);
        check("rst_fwd2", 32'(fwd2), 32'h6F);
        reset = 1'b1;
        #2;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].we,
                  vecs[i].dest, vecs[i].result);
            ex_src1_num = vecs[i].src1; ex_src2_num = vecs[i].src2;
            rf_data1 = vecs[i].rf1; rf_data2 = vecs[i].rf2;
            tick();
            check($sformatf("v%0d_regwrite", i), 32'(rw), 32'(vecs[i].e_rw));
            check($sformatf("v%0d_count", i), 32'(cnt), 32'(vecs[i].e_cnt));
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_wnum", i), 32'(wnum), 32'(vecs[i].e_wnum));
                check($sformatf("v%0d_wdata", i), 32'(wdata), 32'(vecs[i].e_wdata));
            end
`ifdef EX_WB_FORWARDING_EN
            check($sformatf("v%0d_fwd1", i), 32'(fwd1), 32'(vecs[i].e_fwd1));
            check($sformatf("v%0d_fwd2", i), 32'(fwd2), 32'(vecs[i].e_fwd2));
            check($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].e_hit));
`else
            check($sformatf("v%0d_fwd1", i), 32'(fwd1), 32'(vecs[i].rf1));
            check($sformatf("v%0d_fwd2", i), 32'(fwd2), 32'(vecs[i].rf2));
            check($sformatf("v%0d_hit", i), 32'(hit), 32'd0);
`endif
        end

        // Reset mid-operation drops an in-flight write without waiting for a clock
        drive(0, 0, 1, 1, 3'd6, 8'h66);
        tick();
        check("mid_regwrite_before", 32'(rw), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_regwrite_async", 32'(rw), 32'd0);
        check("mid_count_async", 32'(cnt), 32'd0);
        check("mid_wdata_async", 32'(wdata), 32'd0);
        #2 reset = 1'b1;

        // Counter wrap on the 4-bit instance; the 16-bit one keeps counting
        drive(0, 0, 1, 1, 3'd1, 8'h42);
        for (int k = 0; k < 16; k++) tick();
        check("wrap_cnt2_full", 32'(cnt2), 32'd15);
        tick();
        check("wrap_cnt2_zero", 32'(cnt2), 32'd0);
        check("wrap_cnt_main", 32'(cnt), 32'd16);

        // Writes to register 0 are suppressed only on the read-only instance
        drive(0, 0, 1, 1, 3'd0, 8'hEE);
        tick();
        check("r0_main_regwrite", 32'(rw), 32'd1);
        check("r0_ro_regwrite", 32'(rw2), 32'd0);
        drive(0, 0, 0, 0, 3'd0, 8'h00);
        tick();
        check("r0_ro_count", 32'(cnt2), 32'd1);
        check("r0_main_count", 32'(cnt), 32'd18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
